// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM pipeline boundary.
package ex_mem_pkg;

  localparam int unsigned CTRL_MEM_TO_REG = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_PC_W   = 16;
  localparam int unsigned DEF_CTRL_W = 2;

  // Bit 0 means main holds an entry, bit 1 means skid holds an entry.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] alu;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; main entry drives the output.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_e          state_q;
  skid_state_e          state_d;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;
  logic                 accept;
  logic                 consume;

  // Handshake flags come straight off state flops, no path from in_valid/out_ready.
  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a same-cycle input.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline boundary: skid-buffered payload, gated control bits, stall counter.
module ex_mem_stage_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 16,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_alu,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_alu,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Same field order as ex_mem_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] alu;
  } payload_t;

  localparam int unsigned    PAYLOAD_W = $bits(payload_t);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  payload_t         in_pl;
  payload_t         main_pl;
  logic [CNT_W-1:0] stall_q;

  assign in_pl = '{ctrl: in_ctrl, pc: in_pc, rd2: in_rd2, alu: in_alu};

  pipe_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (main_pl)
  );

  // An empty slot must never request a load or store downstream.
  assign out_ctrl  = main_pl.ctrl & {CTRL_W{out_valid}};
  assign out_pc    = main_pl.pc;
  assign out_rd2   = main_pl.rd2;
  assign out_alu   = main_pl.alu;
  assign stall_cnt = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Randomized and directed bench for ex_mem_stage_buf against a queue-based reference model.
module tb_ex_mem_stage_buf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] alu;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_rd2;
  logic [DATA_W-1:0] in_alu;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_alu;
  logic [CNT_W-1:0]  stall_cnt;

  int    total = 0;
  int    bad   = 0;
  beat_t q[$];
  int    stall_m = 0;

  ex_mem_stage_buf #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_pc    (in_pc),
    .in_rd2   (in_rd2),
    .in_alu   (in_alu),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_pc   (out_pc),
    .out_rd2  (out_rd2),
    .out_alu  (out_alu),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.ctrl = CTRL_W'($urandom);
    b.pc   = PC_W'($urandom);
    b.rd2  = $urandom;
    b.alu  = $urandom;
    return b;
  endfunction

  function automatic beat_t mk(input logic [1:0] c, input logic [15:0] p, input logic [31:0] d, input logic [31:0] a);
    beat_t b;
    b.ctrl = c; b.pc = p; b.rd2 = d; b.alu = a;
    return b;
  endfunction

  // Compare every observable output with the model's view of the buffer.
  task automatic check_all();
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    if (q.size() > 0) begin
      check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
      check("out_pc", 64'(out_pc), 64'(q[0].pc));
      check("out_rd2", 64'(out_rd2), 64'(q[0].rd2));
      check("out_alu", 64'(out_alu), 64'(q[0].alu));
    end else begin
      check("out_ctrl_idle", 64'(out_ctrl), 64'd0);
    end
  endtask

  // Called at a falling edge; drives one cycle, advances the model, checks at the next falling edge.
  task automatic do_cycle(input logic iv, input logic fl, input logic ordy, input beat_t b);
    bit acc, con;
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_ctrl   = b.ctrl;
    in_pc     = b.pc;
    in_rd2    = b.rd2;
    in_alu    = b.alu;
    acc = iv && (q.size() < 2);
    con = ordy && (q.size() > 0);
    @(posedge clk);
    if (q.size() > 0 && !ordy && stall_m < CNT_SAT) stall_m++;
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    do_cycle(1'b0, 1'b0, ordy, rnd_beat());
  endtask

  // Asynchronous reset pulse between clock edges, checked before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
    check({tag, "_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_rd2"}, 64'(out_rd2), 64'd0);
    check({tag, "_alu"}, 64'(out_alu), 64'd0);
    check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    q.delete();
    stall_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    beat_t a, b, c;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_pc = '0; in_rd2 = '0; in_alu = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_alu", 64'(out_alu), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Single beat, one-cycle latency.
    do_cycle(1'b1, 1'b0, 1'b1, mk(2'b10, 16'h0010, 32'h1234_5678, 32'hDEAD_BEEF));
    check("t1_alu", 64'(out_alu), 64'hDEAD_BEEF);
    check("t1_ctrl", 64'(out_ctrl), 64'b10);
    check("t1_ready", 64'(in_ready), 64'd1);
    idle(1'b1);

    // Full-rate streaming.
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 1'b1, rnd_beat());
      check("stream_ready", 64'(in_ready), 64'd1);
    end
    idle(1'b1);

    // Backpressure fills the skid, then drains in order.
    a = rnd_beat(); b = rnd_beat();
    do_cycle(1'b1, 1'b0, 1'b0, a);
    do_cycle(1'b1, 1'b0, 1'b0, b);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_head", 64'(out_alu), 64'(a.alu));
    idle(1'b1);
    check("bp_second", 64'(out_alu), 64'(b.alu));
    idle(1'b1);
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_stall", 64'(stall_cnt), 64'd1);

    // Flush in TWO with a same-cycle input.
    do_cycle(1'b1, 1'b0, 1'b0, rnd_beat());
    do_cycle(1'b1, 1'b0, 1'b0, rnd_beat());
    c = mk(2'b11, 16'hBEEF, 32'hCAFE_F00D, 32'h0BAD_0BAD);
    do_cycle(1'b1, 1'b1, 1'b0, c);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    repeat (3) idle(1'b1);

    // Counter saturation.
    do_cycle(1'b1, 1'b0, 1'b0, rnd_beat());
    repeat ((1 << CNT_W) + 5) idle(1'b0);
    check("sat_stall", 64'(stall_cnt), 64'hF);
    idle(1'b1);

    // Asynchronous reset with both entries held.
    do_cycle(1'b1, 1'b0, 1'b0, rnd_beat());
    do_cycle(1'b1, 1'b0, 1'b0, rnd_beat());
    async_reset("arst");
    check_all();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        async_reset("rnd_rst");
      end
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
               $urandom_range(0, 2) != 0, rnd_beat());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_buf.md
# ex_mem_stage_buf

Parametrised EX→MEM pipeline boundary with a valid/ready handshake and 2-entry skid buffer. It replaces the plain always-load EX/MEM register. It carries control bits, PC, store data and ALU result from execute to memory, and adds backpressure, flush (bubble insertion) and a saturating stall counter. It sits between the ALU stage and the data-memory stage of the core pipeline.

## Interface
- DATA_W, 32, width of store-data and ALU-result fields
- PC_W, 16, width of PC field
- CTRL_W, 2, control bits; bit 0 = mem_to_reg, bit 1 = mem_write
- CNT_W, 16, stall-counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX has a valid instruction
- in_ready  out  1  stage can accept (combinational from state only)
- in_ctrl  in  CTRL_W  control bits from EX
- in_pc  in  PC_W  PC of instruction
- in_rd2  in  DATA_W  store data
- in_alu  in  DATA_W  ALU result / address
- flush  in  1  discard all held entries and any same-cycle input
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry
- out_ctrl  out  CTRL_W  control bits, forced 0 when out_valid=0
- out_pc  out  PC_W  PC
- out_rd2  out  DATA_W  store data
- out_alu  out  DATA_W  ALU result
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Accept: in_valid & in_ready at a clock edge. Consume: out_valid & out_ready.
- Two entries: main (drives outputs) and skid. States: EMPTY, ONE (main valid), TWO (main+skid valid).
- EMPTY: accept → ONE, main loads input.
- ONE: accept & consume → ONE, main loads input. Accept & !consume → TWO, skid loads input. !accept & consume → EMPTY. Otherwise hold.
- TWO: in_ready=0. Consume → ONE, main loads skid. Otherwise hold.
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- flush=1: next state EMPTY regardless of accept/consume; input dropped; data registers may keep stale values. flush overrides all.
- out_ctrl = main.ctrl & {CTRL_W{out_valid}}. An invalid slot never asserts mem_write or mem_to_reg.
- Data fields load only on accept or skid→main transfer; no data-dependent behaviour. Fields are carried at full width with no truncation.
- stall_cnt increments when out_valid & !out_ready, saturates at all-ones, and is cleared only by rst. flush does not clear it.

## Timing
- Latency: 1 cycle. Data accepted at edge N appears on out_* after edge N with out_valid=1.
- Throughput: 1 per cycle while out_ready=1. The skid absorbs one extra beat after out_ready drops, and in_ready falls one cycle later.
- in_ready, out_valid and out_ctrl depend only on state and registers, with no combinational path from out_ready or in_valid.
- Reset values: state EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_pc=0, out_rd2=0, out_alu=0, stall_cnt=0. Skid registers are also 0.
- Reset mid-transfer: all entries lost immediately (asynchronous), no partial output.
- Order is preserved. An entry in skid is never presented before main.

## Structure
- Package ex_mem_pkg: state enum {EMPTY, ONE, TWO}, CTRL_MEM_TO_REG=0, CTRL_MEM_WRITE=1 index constants, and a packed struct typedef for the payload {ctrl, pc, rd2, alu}.
- One sub-module, pipe_skid_buf #(PAYLOAD_W): a generic 2-entry valid/ready skid buffer with flush. The top level packs and unpacks the payload struct, applies ctrl gating and holds the stall counter.

## Test plan
- Reset, then send in_pc=0x0010, in_alu=0xDEADBEEF, in_ctrl=2'b10 with out_ready=1 → next cycle out_valid=1, out_alu=0xDEADBEEF, out_ctrl=2'b10; in_ready stays 1.
- Stream 4 beats with out_ready=1 → outputs in order, one per cycle, in_ready never drops.
- Send A and B while out_ready=0 → after B, in_ready=0 and out shows A. Raise out_ready → A, then B, on consecutive cycles, then out_valid=0. stall_cnt equals the number of held cycles.
- flush asserted in state TWO with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; the dropped input never appears.
- Hold out_valid=1 with out_ready=0 for 2^CNT_W+5 cycles (CNT_W=4 build) → stall_cnt sticks at 0xF.
- Assert rst asynchronously mid-stream → outputs zero before the next clock edge, and state is EMPTY after release.
